// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the icestick pmod button/counter projects:
// FSM encodings, board clock default and the standard debounce length.
package counter_ctrl_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // 12 MHz icestick oscillator
  localparam int DEFAULT_CLK_HZ = 12_000_000;

  // 10 ms of stable level at 12 MHz before a button level is accepted
  localparam int DEFAULT_DEBOUNCE_CYCLES = 120_000;

  // Bits needed to hold the values 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Button inputs and LED/status outputs of the run/stop/step counter.
// The board side (buttons, LEDs) is the master, the controller is the slave.
interface counter_ctrl_if #(
  parameter int WIDTH = 4
);

  logic             btn_run;
  logic             btn_step;
  logic             btn_dir;
  logic [WIDTH-1:0] led;
  logic             running;
  logic             tick;
  logic             dir_down;

  modport master (
    output btn_run, btn_step, btn_dir,
    input  led, running, tick, dir_down
  );

  modport slave (
    input  btn_run, btn_step, btn_dir,
    output led, running, tick, dir_down
  );

endinterface

// File: rtl/counter_ctrl_btn_debounce.sv
// Conditions one raw active-low push-button: two-flop synchronizer,
// consecutive-sample debounce counter and a press (1->0) edge pulse.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam int CW = cnt_width(CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clk domain; idles released (1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Accept a new level after CYCLES differing samples in a row; pulse on press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        cnt    <= '0;
        stable <= sync_q[1];
        press  <= stable;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run/stop/step controller for the icestick 4-bit LED counter.
// Three debounced buttons drive a RUNNING/STOPPED FSM; a prescaler paces
// the count while running, a step button advances it while stopped.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WIDTH           = 4
) (
  input  logic clk,
  input  logic rst_n,
  counter_ctrl_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = cnt_width(DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic run_stable, step_stable, dir_stable;
  logic run_press, step_press, dir_press;
  logic run_ev, step_ev, dir_ev;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] next_led;
  logic             tick_q;
  logic             dir_q;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_run),
    .stable  (run_stable),
    .press   (run_press)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_step),
    .stable  (step_stable),
    .press   (step_press)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (bus.btn_dir),
    .stable  (dir_stable),
    .press   (dir_press)
  );

  // A press pulse always coincides with the level having just gone low
  assign run_ev  = run_press  & ~run_stable;
  assign step_ev = step_press & ~step_stable;
  assign dir_ev  = dir_press  & ~dir_stable;

  // Modulo advance in the direction currently in force
  assign next_led = dir_q ? (led_q - ONE) : (led_q + ONE);

  // FSM, prescaler, direction and LED count; run beats a same-cycle advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_STOPPED;
      presc  <= '0;
      led_q  <= '0;
      tick_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (dir_ev) begin
        dir_q <= ~dir_q;
      end
      case (state)
        ST_STOPPED: begin
          presc <= '0;
          if (run_ev) begin
            state <= ST_RUNNING;
          end else if (step_ev) begin
            led_q  <= next_led;
            tick_q <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (run_ev) begin
            state <= ST_STOPPED;
            presc <= '0;
          end else if (presc == PW'(DIV - 1)) begin
            presc  <= '0;
            led_q  <= next_led;
            tick_q <= 1'b1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: begin
          state <= ST_STOPPED;
          presc <= '0;
        end
      endcase
    end
  end

  assign bus.led      = led_q;
  assign bus.running  = (state == ST_RUNNING);
  assign bus.tick     = tick_q;
  assign bus.dir_down = dir_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random button traffic,
// compared every cycle against a sliding-window / event-level reference.
module tb_counter_ctrl;

  localparam int WIDTH   = 4;
  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int DEB     = 4;
  localparam int HW      = DEB + 2;
  localparam int MOD     = 1 << WIDTH;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pins  = 3'b111;

  counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  assign bus.btn_run  = pins[0];
  assign bus.btn_step = pins[1];
  assign bus.btn_dir  = pins[2];

  counter_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DEB),
    .WIDTH           (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int tick_seen = 0;

  // Reference state: pin sample history, accepted levels, pending events
  logic [HW-1:0]    hist [3];
  logic [2:0]       m_stable;
  logic [2:0]       m_press;
  logic             m_running;
  logic             m_dir;
  logic             m_tick;
  logic [WIDTH-1:0] m_led;
  int               m_run_start;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) hist[b] = '1;
    m_stable    = 3'b111;
    m_press     = 3'b000;
    m_running   = 1'b0;
    m_dir       = 1'b0;
    m_tick      = 1'b0;
    m_led       = '0;
    m_run_start = 0;
    cyc         = 0;
  endtask

  // One clock edge of the reference: act on events accepted last cycle,
  // then slide each button's sample window to find this cycle's presses.
  task automatic model_edge();
    logic adv;
    adv = 1'b0;
    cyc++;
    if (m_running) begin
      if (m_press[0]) m_running = 1'b0;
      else if (((cyc - m_run_start) % DIV) == 0) adv = 1'b1;
    end else begin
      if (m_press[0]) begin
        m_running   = 1'b1;
        m_run_start = cyc;
      end else if (m_press[1]) begin
        adv = 1'b1;
      end
    end
    if (adv) m_led = WIDTH'((int'(m_led) + (m_dir ? MOD - 1 : 1)) % MOD);
    m_tick = adv;
    if (m_press[2]) m_dir = ~m_dir;
    for (int b = 0; b < 3; b++) begin
      hist[b]    = {hist[b][HW-2:0], pins[b]};
      m_press[b] = 1'b0;
      if (hist[b][HW-1:2] == '0 && m_stable[b]) begin
        m_stable[b] = 1'b0;
        m_press[b]  = 1'b1;
      end else if (hist[b][HW-1:2] == '1 && !m_stable[b]) begin
        m_stable[b] = 1'b1;
      end
    end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    tick_seen += int'(bus.tick);
    expect_eq("led",      32'(bus.led),      32'(m_led));
    expect_eq("running",  32'(bus.running),  32'(m_running));
    expect_eq("tick",     32'(bus.tick),     32'(m_tick));
    expect_eq("dir_down", 32'(bus.dir_down), 32'(m_dir));
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pins = {d, s, r};
      @(posedge clk);
      model_edge();
      #1;
      checkOutput();
    end
  endtask

  task automatic wait_led(input logic [WIDTH-1:0] val, input int limit);
    int n;
    n = 0;
    while (m_led != val && n < limit) begin
      applyStimulus(H, H, H, 1);
      n++;
    end
    expect_eq("wait_led", 32'(bus.led), 32'(val));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] led_before;
    logic [2:0]       mask;
    int               t_enter;
    int               t_tick;
    int               hold;
    int               gap;

    $display("[TB] reset and idle");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst_led",     32'(bus.led),      32'd0);
    expect_eq("rst_running", 32'(bus.running),  32'd0);
    expect_eq("rst_tick",    32'(bus.tick),     32'd0);
    expect_eq("rst_dir",     32'(bus.dir_down), 32'd0);
    #1 rst_n = 1'b1;
    tick_seen = 0;
    applyStimulus(H, H, H, 100);
    expect_eq("idle_ticks", 32'(tick_seen), 32'd0);
    expect_eq("idle_led",   32'(bus.led),   32'd0);

    $display("[TB] step glitch then clean step");
    applyStimulus(H, L, H, 2);
    applyStimulus(H, H, H, 10);
    expect_eq("glitch_led", 32'(bus.led), 32'd0);
    tick_seen = 0;
    applyStimulus(H, L, H, 20);
    applyStimulus(H, H, H, 10);
    expect_eq("step_ticks", 32'(tick_seen), 32'd1);
    expect_eq("step_led",   32'(bus.led),   32'd1);

    $display("[TB] run through the 15->0 wrap");
    applyStimulus(L, H, H, 8);
    expect_eq("run_enter", 32'(bus.running), 32'd1);
    wait_led(WIDTH'(0), 200);
    expect_eq("wrap_running", 32'(bus.running), 32'd1);

    $display("[TB] direction toggle and step while running");
    wait_led(WIDTH'(2), 200);
    applyStimulus(H, H, L, 8);
    expect_eq("dir_set", 32'(bus.dir_down), 32'd1);
    wait_led(WIDTH'(1), 20);
    wait_led(WIDTH'(0), 20);
    wait_led(WIDTH'(15), 20);
    tick_seen = 0;
    applyStimulus(H, L, H, 8);
    applyStimulus(H, H, H, 1);
    expect_eq("step_ignored_ticks", 32'(tick_seen), 32'd0);
    expect_eq("step_ignored_led",   32'(bus.led),   32'd15);

    $display("[TB] run event on a prescaler wrap");
    for (int i = 0; i < DIV && ((cyc + DEB + 3 - m_run_start) % DIV) != 0; i++)
      applyStimulus(H, H, H, 1);
    applyStimulus(L, H, H, DEB + 2);
    led_before = bus.led;
    applyStimulus(L, H, H, 1);
    expect_eq("coll_running", 32'(bus.running), 32'd0);
    expect_eq("coll_tick",    32'(bus.tick),    32'd0);
    expect_eq("coll_led",     32'(bus.led),     32'(led_before));
    applyStimulus(L, H, H, 2);
    applyStimulus(H, H, H, 10);

    $display("[TB] first tick after re-entering RUNNING");
    t_enter = -1;
    t_tick  = -1;
    for (int i = 0; i < 40 && t_tick < 0; i++) begin
      applyStimulus((i < 8) ? L : H, H, H, 1);
      if (t_enter < 0 && bus.running === 1'b1) t_enter = cyc;
      else if (t_enter >= 0 && bus.tick === 1'b1) t_tick = cyc;
    end
    expect_eq("rerun_latency", 32'(t_tick - t_enter), 32'(DIV));

    $display("[TB] random button traffic");
    for (int it = 0; it < 40; it++) begin
      mask = 3'($urandom_range(7, 1));
      hold = int'($urandom_range(10, 1));
      gap  = int'($urandom_range(12, 1));
      applyStimulus(~mask[0], ~mask[1], ~mask[2], hold);
      applyStimulus(H, H, H, gap);
    end

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(H, H, H, 10);
    if (!m_running) begin
      applyStimulus(L, H, H, 8);
      applyStimulus(H, H, H, 2);
    end
    wait_led(WIDTH'(9), 200);
    #2 rst_n = 1'b0;
    pins = 3'b000;
    #1;
    expect_eq("arst_led",     32'(bus.led),      32'd0);
    expect_eq("arst_running", 32'(bus.running),  32'd0);
    expect_eq("arst_dir",     32'(bus.dir_down), 32'd0);
    expect_eq("arst_tick",    32'(bus.tick),     32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    tick_seen = 0;
    applyStimulus(L, L, L, 2);
    applyStimulus(H, H, H, 30);
    expect_eq("post_rst_ticks",   32'(tick_seen),   32'd0);
    expect_eq("post_rst_running", 32'(bus.running), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Button-driven run/stop/step controller for the 4-bit LED counter on the icestick board. It debounces three raw pmod push-buttons and runs a small RUNNING/STOPPED state machine. A prescaler generates the advance tick. The block drives the LED count up or down with modulo wrap, replacing free-running count-and-display with user sequencing.

Parameters:
CLK_HZ, 12000000, input clock frequency in Hz.
TICK_HZ, 1, advance rate while RUNNING; prescaler period DIV = CLK_HZ/TICK_HZ cycles (DIV >= 2).
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a button level (10 ms at 12 MHz).
WIDTH, 4, LED counter width.

Ports:
clk  input  1  12 MHz system clock
rst_n  input  1  asynchronous reset, active-low
btn_run  input  1  raw run/stop button, active-low (pull-up), asynchronous to clk
btn_step  input  1  raw single-step button, active-low, asynchronous
btn_dir  input  1  raw direction-toggle button, active-low, asynchronous
led  output  WIDTH  current count driven to LEDs
running  output  1  high while the FSM is in RUNNING
tick  output  1  one-cycle pulse on every cycle in which led changes
dir_down  output  1  0 = count up, 1 = count down

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-safe release): led=0, running=0, tick=0, dir_down=0, prescaler=0, FSM=STOPPED. All debouncer stable levels = 1 (released), so no event is generated after reset.
- Input conditioning per button: 2-FF synchronizer, then debounce counter.
  - Stable level updates only after DEBOUNCE_CYCLES consecutive cycles of an identical synchronized value.
  - Any differing sample restarts the count.
  - Press event = one-cycle pulse on a stable 1->0 transition. Release generates nothing.
- Latency: a clean press produces its event DEBOUNCE_CYCLES+2 cycles after the pin falls (±1). led/state respond on the following clock edge.
- FSM states:
  - STOPPED: run event -> RUNNING. Step event -> led advances by one; tick=1.
  - RUNNING: run event -> STOPPED. Step events are ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING. At DIV-1 it wraps to 0 and advances led (tick=1).
  - Forced to 0 in STOPPED. The first advance after entering RUNNING occurs exactly DIV cycles after the transition edge.
- Advance arithmetic: led +1 if dir_down=0, -1 if dir_down=1, modulo 2^WIDTH. Wrap cases: 15+1 -> 0 and 0-1 -> 15, silent.
- Dir event toggles dir_down in either state.
- Simultaneous events, same cycle:
  - run event + prescaler wrap: run has priority. The FSM goes to STOPPED, led is unchanged, tick=0.
  - dir event + advance: the advance uses the old direction. The new direction applies from the next cycle.
  - run + step while STOPPED: enter RUNNING, step ignored.
  - Events from different buttons are otherwise independent.
- Held buttons: no auto-repeat. Exactly one event per debounced press.
- Reset mid-debounce or mid-prescale: all counters clear immediately. Partial presses are discarded.

Decomposition:
- Shared package / include: FSM state encodings (ST_STOPPED=1'b0, ST_RUNNING=1'b1), default CLK_HZ, and the DEBOUNCE_CYCLES constant, for reuse by other icestick pmod projects.
- Sub-module btn_debounce (params CYCLES):
  - Ports: clk, rst_n, btn_raw, stable, press.
  - Contains the synchronizer, the debounce counter and the edge detector.
  - Instantiated three times.
- counter_ctrl holds the FSM, prescaler, direction register and led counter.

Test Plan:
(Bench parameters DIV=10, DEBOUNCE_CYCLES=4.)
- Reset and idle: assert rst_n=0 with all buttons at 1, then release and idle 100 cycles -> led=0, running=0, tick never 1.
- Step debounce: apply a btn_step glitch low for 2 cycles -> no change. Then hold low for 20 cycles -> led=1 with exactly one tick, about 7 cycles after the fall.
- Run sequence: press btn_run -> running=1; ticks every 10 cycles; led 1,2,3... Continue until the 15->0 wrap; check the 15->0 step.
- Direction and step-while-running: from led=2 running, press btn_dir -> subsequent ticks give 1,0,15. Press btn_step while running -> no extra tick.
- Run/wrap collision: time the btn_run event onto a prescaler-wrap cycle -> running=0, led unchanged, tick=0 that cycle. Re-run -> first tick exactly 10 cycles after re-entry.
- Asynchronous reset mid-run: drop rst_n asynchronously (between edges) while running with led=9 -> immediate led=0, running=0, dir_down=0; no event when buttons are released afterwards.
